// File: rtl/memory_arb_pkg.sv
// Shared types for the memory read arbiter.
// The requester-id type is sized for the largest supported requester count;
// each arbiter instance checks at elaboration that its own N_REQ fits.
package memory_arb_pkg;

  // Largest requester count any arbiter instance may be built with.
  localparam int ARB_N_REQ_MAX = 16;
  localparam int ARB_ID_WIDTH  = $clog2(ARB_N_REQ_MAX);

  // Fixed-latency memory needs at least one register stage between
  // address acceptance and data return.
  localparam int MEM_LATENCY_MIN = 1;

  typedef logic [ARB_ID_WIDTH-1:0] arb_id_t;

  // One stage of the in-flight read tracker.
  typedef struct packed {
    logic    valid;
    arb_id_t id;
  } inflight_t;

endpackage

// File: rtl/rr_pointer_select.sv
// Round-robin winner selection, purely combinational.
// Ports: req (request vector), last_grant (previous winner),
//        winner (first asserted req above last_grant, wrapping), any (|req).
module rr_pointer_select
  import memory_arb_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] req,
  input  arb_id_t          last_grant,
  output arb_id_t          winner,
  output logic             any
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] pick_vec;

  // Mask keeps only positions strictly above the previous winner.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mask[i] = (arb_id_t'(i) > last_grant);
    end
  end

  assign masked = req & mask;

  // If nothing is pending above the pointer, wrap around to the full vector.
  assign pick_vec = (|masked) ? masked : req;

  // Lowest set bit of pick_vec: scan downward so the last hit is the lowest.
  always_comb begin
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pick_vec[i]) begin
        winner = arb_id_t'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/memory_read_arbiter_rr.sv
// Round-robin arbiter sharing one fixed-latency memory read port among N_REQ
// requesters; tracks the id of every in-flight read and strobes its response.
// Ports: req_valid/req_addr/req_ready (requesters), rsp_valid/rsp_data
//        (one-hot response strobe + broadcast data), mem_valid/mem_addr/
//        mem_ready/mem_data (memory), busy. clk rising edge, rst async active-low.
// Optional: define MEMORY_ARB_CC_PRIORITY_EN to give requester N_REQ-1
// (character-control port) absolute priority over the round-robin ring.
module memory_read_arbiter_rr
  import memory_arb_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic                        mem_valid,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic                        mem_ready,
  input  logic [DATA_WIDTH-1:0]       mem_data,
  output logic                        busy
);

  localparam int ID_WIDTH = $clog2(N_REQ);

  if (MEM_LATENCY < MEM_LATENCY_MIN) begin : g_bad_latency
    $error("memory_read_arbiter_rr: MEM_LATENCY must be >= 1");
  end
  if (N_REQ < 2 || ID_WIDTH > ARB_ID_WIDTH) begin : g_bad_nreq
    $error("memory_read_arbiter_rr: N_REQ out of supported range");
  end

  arb_id_t   last_grant;
  arb_id_t   rr_winner;
  arb_id_t   winner;
  logic      any_req;
  logic      xfer;
  inflight_t pipe [MEM_LATENCY];

  rr_pointer_select #(
    .N_REQ (N_REQ)
  ) u_select (
    .req        (req_valid),
    .last_grant (last_grant),
    .winner     (rr_winner),
    .any        (any_req)
  );

`ifdef MEMORY_ARB_CC_PRIORITY_EN
  logic cc_win;
  assign cc_win = req_valid[N_REQ-1];
  assign winner = cc_win ? arb_id_t'(N_REQ - 1) : rr_winner;
`else
  assign winner = rr_winner;
`endif

  // Selection is not locked: the winner may change while mem_ready is low.
  assign mem_valid = any_req;
  assign xfer      = any_req & mem_ready;

  always_comb begin
    mem_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == arb_id_t'(i)) begin
        mem_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = xfer && (winner == arb_id_t'(i));
    end
  end

  // Pointer starts at the top so requester 0 is first after reset.
  // Priority grants to the character-control port leave the ring untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= arb_id_t'(N_REQ - 1);
`ifdef MEMORY_ARB_CC_PRIORITY_EN
    end else if (xfer && !cc_win) begin
`else
    end else if (xfer) begin
`endif
      last_grant <= winner;
    end
  end

  // In-flight tracker shifts every cycle, independent of mem_ready, since the
  // memory returns data on a fixed schedule. Reset drops anything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0].valid <= xfer;
      pipe[0].id    <= winner;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = pipe[MEM_LATENCY-1].valid && (pipe[MEM_LATENCY-1].id == arb_id_t'(i));
    end
  end

  assign rsp_data = mem_data;

  always_comb begin
    busy = |req_valid;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      busy = busy | pipe[i].valid;
    end
  end

endmodule
